mat_stream_io: RTL and testbench

Streaming front/back end for the packed 2x2 matrix multiplier. It deserializes a byte stream of operand elements into packed 32-bit A and B words and drives them to the multiplier. It then captures the multiplier's packed result and serializes it back out as a byte stream. The block sits between the system's element-wide valid/ready fabric and the combinational multiplier, which has no clock, handshake or flow control of its own.

---
 rtl/mat_pkg.sv | 33 +++
 rtl/mat_serializer.sv | 75 +++++++
 rtl/mat_stream_io.sv | 153 +++++++++++++++
 tb/tb_mat_stream_io.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mat_pkg
// Description : Shared definitions for the 2x2 matrix stream front/back end.
//               Element width default, packed matrix width, the control state
//               encoding and the slot ordering of a packed matrix word.
//               Packing: [4W-1:3W]=M[0][0], [3W-1:2W]=M[0][1],
//                        [2W-1:W]=M[1][0],  [W-1:0]=M[1][1].
// Revision    : 1.0 - initial release
// ============================================================================
package mat_pkg;

    localparam int ELEM_W = 8;
    localparam int MAT_W  = 4 * ELEM_W;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Slot 0 is M[0][0] (MSB field), slot 3 is M[1][1] (LSB field).
    localparam int c_NUM_SLOTS  = 4;
    localparam int c_SLOT_FIRST = 0;
    localparam int c_SLOT_LAST  = 3;

    // Bit offset of the least significant bit of a slot inside a packed word.
    function automatic int slot_lsb(input int slot, input int w);
        return (c_NUM_SLOTS - 1 - slot) * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mat_serializer.sv
`default_nettype none
// ============================================================================
// Module      : mat_serializer
// Description : Holds the captured packed product (res_q) and emits it as four
//               elements on a valid/ready egress port, MSB slot first.
//               A one-cycle load pulse snapshots res and starts a drain.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               load          - snapshot res and begin draining
//               res           - packed product from the multiplier
//               m_valid/m_ready/m_data/m_last - egress element stream
//               done          - final (m_last) handshake happens this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mat_serializer
    import mat_pkg::*;
#(
    parameter int ELEM_W = mat_pkg::ELEM_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*ELEM_W-1:0] res,
    input  logic                m_ready,
    output logic                m_valid,
    output logic [ELEM_W-1:0]   m_data,
    output logic                m_last,
    output logic                done
);

    localparam int MAT_LW = 4 * ELEM_W;

    logic [MAT_LW-1:0] r_res_q;
    logic [1:0]        r_out_cnt;
    logic              r_active;
    logic              w_fire;
    logic              w_at_last;

    assign w_fire    = r_active && m_ready;
    assign w_at_last = (r_out_cnt == c_SLOT_LAST[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_q   <= '0;
            r_out_cnt <= '0;
            r_active  <= 1'b0;
        end else if (load) begin
            // The snapshot isolates the drain from operands that may already
            // be changing underneath for the next frame.
            r_res_q   <= res;
            r_out_cnt <= c_SLOT_FIRST[1:0];
            r_active  <= 1'b1;
        end else if (w_fire) begin
            r_out_cnt <= r_out_cnt + 2'd1;
            if (w_at_last) begin
                r_active <= 1'b0;
            end
        end
    end

    // Outputs depend only on registered state, so they hold while stalled.
    always_comb begin
        m_data = '0;
        for (int i = 0; i < c_NUM_SLOTS; i++) begin
            if (r_out_cnt == i[1:0]) begin
                m_data = r_res_q[slot_lsb(i, ELEM_W) +: ELEM_W];
            end
        end
    end

    assign m_valid = r_active;
    assign m_last  = r_active && w_at_last;
    assign done    = w_fire && w_at_last;

endmodule
`default_nettype wire

// File: rtl/mat_stream_io.sv
`default_nettype none
// ============================================================================
// Module      : mat_stream_io
// Description : Streaming front/back end for the packed 2x2 matrix multiplier.
//               Deserializes 8 ingress elements (A row-major, then B) into
//               packed mat_a/mat_b, captures the combinational product for one
//               cycle, then serializes it out as 4 elements.
// Ports       : clk, rst                 - clock, sync active-high reset
//               s_valid/s_ready/s_data   - ingress element stream
//               mat_a, mat_b             - packed operands to the multiplier
//               mat_res                  - packed product from the multiplier
//               m_valid/m_ready/m_data/m_last - egress element stream
//               busy                     - not idle (LOAD with nothing held)
// Config      : MAT_STREAM_OVERLAP_EN - when defined, the next frame is loaded
//               while the previous result drains.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_stream_io
    import mat_pkg::*;
#(
    parameter int ELEM_W = mat_pkg::ELEM_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [ELEM_W-1:0]   s_data,
    output logic [4*ELEM_W-1:0] mat_a,
    output logic [4*ELEM_W-1:0] mat_b,
    input  logic [4*ELEM_W-1:0] mat_res,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [ELEM_W-1:0]   m_data,
    output logic                m_last,
    output logic                busy
);

    localparam int MAT_LW = 4 * ELEM_W;

`ifdef MAT_STREAM_OVERLAP_EN
    localparam bit c_OVERLAP = 1'b1;
`else
    localparam bit c_OVERLAP = 1'b0;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_in_cnt;
    logic [MAT_LW-1:0] r_mat_a;
    logic [MAT_LW-1:0] r_mat_b;
    logic              r_full;      // next frame fully loaded, drain pending
    logic              w_acc;
    logic              w_last_acc;
    logic              w_load;
    logic              w_done;

    assign s_ready = !rst &&
                     ((r_state == LOAD) ||
                      (c_OVERLAP && (r_state == DRAIN) && !r_full));

    assign w_acc      = s_valid && s_ready;
    assign w_last_acc = w_acc && (r_in_cnt == 3'd7);
    assign w_load     = (r_state == CAPTURE);

    // ------------------------------------------------------------------------
    // Deserializer: beats 0..3 fill A, beats 4..7 fill B, MSB slot first.
    // Operands are only ever overwritten, never cleared between frames.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_cnt <= '0;
            r_mat_a  <= '0;
            r_mat_b  <= '0;
        end else if (w_acc) begin
            r_in_cnt <= r_in_cnt + 3'd1;
            for (int i = 0; i < c_NUM_SLOTS; i++) begin
                if (r_in_cnt[1:0] == i[1:0]) begin
                    if (r_in_cnt[2]) begin
                        r_mat_b[slot_lsb(i, ELEM_W) +: ELEM_W] <= s_data;
                    end else begin
                        r_mat_a[slot_lsb(i, ELEM_W) +: ELEM_W] <= s_data;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
            r_full  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Only reachable with overlap: s_ready is never high in DRAIN
            // otherwise, so w_last_acc cannot occur there.
            r_full  <= (r_state == DRAIN) && !w_done && (r_full || w_last_acc);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD: begin
                if (w_last_acc) begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_done) begin
                    // A complete next frame (held, or finishing this very
                    // edge) skips LOAD and is captured immediately.
                    if (r_full || w_last_acc) begin
                        w_state_nxt = CAPTURE;
                    end else begin
                        w_state_nxt = LOAD;
                    end
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Egress
    // ------------------------------------------------------------------------
    mat_serializer #(
        .ELEM_W (ELEM_W)
    ) u_serializer (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .res     (mat_res),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .done    (w_done)
    );

    assign mat_a = r_mat_a;
    assign mat_b = r_mat_b;
    assign busy  = !((r_state == LOAD) && (r_in_cnt == 3'd0));

endmodule
`default_nettype wire

// File: tb/tb_mat_stream_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_mat_stream_io
// Description : Self-checking bench for mat_stream_io with an attached
//               combinational 2x2 multiplier (mod 256). Table of frames plus
//               directed sequences for stalls, resets and drain overlap.
// Config      : MAT_STREAM_OVERLAP_EN selects the overlap expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_stream_io;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic [31:0] mat_a;
    logic [31:0] mat_b;
    logic [31:0] mat_res;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    mat_stream_io #(.ELEM_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .mat_a   (mat_a),
        .mat_b   (mat_b),
        .mat_res (mat_res),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 2x2 multiplier, elements truncated to 8 bits.
    function automatic logic [31:0] mul2(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3, c0, c1, c2, c3;
        {a0, a1, a2, a3} = a;
        {b0, b1, b2, b3} = b;
        c0 = a0 * b0 + a1 * b2;
        c1 = a0 * b1 + a1 * b3;
        c2 = a2 * b0 + a3 * b2;
        c3 = a2 * b1 + a3 * b3;
        return {c0, c1, c2, c3};
    endfunction

    assign mat_res = mul2(mat_a, mat_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one element and wait (bounded) for acceptance.
    task automatic send(input logic [7:0] d);
        bit r;
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int c = 0; c < 100; c++) begin
            r = s_ready;
            tick();
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input int max_gap);
        logic [63:0] w;
        w = {a, b};
        for (int k = 0; k < 8; k++) begin
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(0, max_gap);
                for (int j = 0; j < g; j++) tick();
            end
            send(w[63 - 8*k -: 8]);
        end
    endtask

    // Wait (bounded) for one egress handshake; m_ready set by the caller.
    task automatic recv(output logic [7:0] d, output logic l);
        bit ok;
        ok = 1'b0;
        d  = 8'h00;
        l  = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (m_valid && m_ready) begin
                d  = m_data;
                l  = m_last;
                ok = 1'b1;
            end
            tick();
            if (ok) break;
        end
        if (!ok) chk("recv_timeout", 32'd0, 32'd1);
    endtask

    task automatic recv_result(input string name, input logic [31:0] exp);
        logic [7:0] d;
        logic       l;
        for (int i = 0; i < 4; i++) begin
            recv(d, l);
            chk({name, "_data"}, {24'd0, d}, {24'd0, exp[31 - 8*i -: 8]});
            chk({name, "_last"}, {31'd0, l}, {31'd0, (i == 3)});
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [7:0] d;
        logic       l;
        int         cnt;

        vecs[0] = '{a: 32'h01020304, b: 32'h05060708, r: 32'h13162B32};
        vecs[1] = '{a: 32'h10101010, b: 32'h10101010, r: 32'h00000000};
        vecs[2] = '{a: 32'h01000001, b: 32'hC8643219, r: 32'hC8643219};
        vecs[3] = '{a: 32'h02030405, b: 32'h01010101, r: 32'h05050909};
        vecs[4] = '{a: 32'h01020304, b: 32'h00010100, r: 32'h02010403};

        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_last",  {31'd0, m_last},  32'd0);
        chk("rst_m_data",  {24'd0, m_data},  32'd0);
        chk("rst_mat_a",   mat_a, 32'd0);
        chk("rst_mat_b",   mat_b, 32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        rst = 1'b0;
        tick();
        chk("load_s_ready", {31'd0, s_ready}, 32'd1);

        // ---------------- table of frames ----------------
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].a, vecs[v].b, 0);
            chk("capture_no_valid", {31'd0, m_valid}, 32'd0);
            chk("capture_busy", {31'd0, busy}, 32'd1);
            chk("mat_a", mat_a, vecs[v].a);
            chk("mat_b", mat_b, vecs[v].b);
            tick();
            chk("first_valid", {31'd0, m_valid}, 32'd1);
            recv_result("vec", vecs[v].r);
            tick();
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end

        // ---------------- backpressure and ingress gaps ----------------
        begin
            bit         pat [4];
            bit         held;
            logic [7:0] hd;
            logic       hl;
            logic [31:0] exp;
            int         got;
            pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
            exp  = 32'h13162B32;
            held = 1'b0; hd = 8'h00; hl = 1'b0; got = 0;
            send_frame(32'h01020304, 32'h05060708, 2);
            for (int c = 0; c < 60 && got < 4; c++) begin
                m_ready = pat[c % 4];
                if (held) begin
                    chk("bp_hold_valid", {31'd0, m_valid}, 32'd1);
                    chk("bp_hold_data",  {24'd0, m_data},  {24'd0, hd});
                    chk("bp_hold_last",  {31'd0, m_last},  {31'd0, hl});
                end
                held = m_valid && !m_ready;
                hd = m_data;
                hl = m_last;
                if (m_valid && m_ready) begin
                    chk("bp_data", {24'd0, m_data}, {24'd0, exp[31 - 8*got -: 8]});
                    chk("bp_last", {31'd0, m_last}, {31'd0, (got == 3)});
                    got++;
                end
                tick();
            end
            chk("bp_count", got, 32'd4);
            m_ready = 1'b1;
        end

        // ---------------- s_ready during DRAIN ----------------
        m_ready = 1'b0;
        send_frame(32'h01020304, 32'h05060708, 0);
        tick();
`ifndef MAT_STREAM_OVERLAP_EN
        s_valid = 1'b1;
        s_data  = 8'hEE;
`endif
        for (int c = 0; c < 4; c++) begin
            chk("drain_valid", {31'd0, m_valid}, 32'd1);
`ifdef MAT_STREAM_OVERLAP_EN
            chk("drain_s_ready", {31'd0, s_ready}, 32'd1);
`else
            chk("drain_s_ready", {31'd0, s_ready}, 32'd0);
`endif
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        recv_result("drain", 32'h13162B32);
        chk("drain_mat_a", mat_a, 32'h01020304);
        chk("drain_mat_b", mat_b, 32'h05060708);

        // ---------------- reset mid-load ----------------
        send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D); send(8'h0E);
        rst = 1'b1;
        tick();
        chk("rml_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rml_mat_a", mat_a, 32'd0);
        chk("rml_mat_b", mat_b, 32'd0);
        chk("rml_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        send_frame(32'h01020304, 32'h05060708, 0);
        recv_result("rml", 32'h13162B32);

        // ---------------- reset mid-drain ----------------
        send_frame(32'h02030405, 32'h01010101, 0);
        recv(d, l);
        chk("rmd_b0", {24'd0, d}, 32'h05);
        recv(d, l);
        chk("rmd_b1", {24'd0, d}, 32'h05);
        rst = 1'b1;
        tick();
        chk("rmd_valid", {31'd0, m_valid}, 32'd0);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (m_valid) cnt++;
            tick();
        end
        chk("rmd_no_egress", cnt, 32'd0);

`ifdef MAT_STREAM_OVERLAP_EN
        // ---------------- overlapped frames ----------------
        m_ready = 1'b0;
        send_frame(32'h01020304, 32'h05060708, 0);
        fork
            begin
                send_frame(32'h01000001, 32'hC8643219, 0);
                chk("ovl_stall_s_ready", {31'd0, s_ready}, 32'd0);
                chk("ovl_stall_valid", {31'd0, m_valid}, 32'd1);
            end
            begin
                for (int c = 0; c < 10; c++) tick();
                m_ready = 1'b1;
                recv_result("ovl1", 32'h13162B32);
                recv_result("ovl2", 32'hC8643219);
            end
        join
        tick();
        chk("ovl_idle", {31'd0, busy}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
